// File: rtl/ntm_vector_subtractor.sv
// ntm_vector_subtractor: streaming element-wise a-b over SIZE_IN-element vectors with enable-qualified operand streams.
// Optional NTM_VECTOR_SUBTRACTOR_SATURATE_EN clamps negative differences to zero.
module ntm_vector_subtractor #(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_IN   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 data_a_in_enable_i,
  input  logic [DATA_SIZE-1:0] data_a_in_i,
  input  logic                 data_b_in_enable_i,
  input  logic [DATA_SIZE-1:0] data_b_in_i,
  output logic                 data_enable_o,
  output logic [DATA_SIZE:0]   data_out_o,
  output logic                 data_out_enable_o,
  output logic                 ready_o
);
  localparam int IW = SIZE_IN > 1 ? $clog2(SIZE_IN) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INPUT = 2'd1;
  localparam logic [1:0] ENDER = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 a_held_q, a_held_d, b_held_q, b_held_d;
  logic [DATA_SIZE-1:0] a_q, a_d, b_q, b_d, a_val, b_val;
  logic [DATA_SIZE:0]   out_q, out_d, diff, res;
  logic                 oe_q, oe_d, ready_q, ready_d;
  logic                 in_input, a_take, b_take, pair, last;
  always_comb begin
    in_input = state_q == INPUT;
    a_take   = in_input & data_a_in_enable_i & ~a_held_q;
    b_take   = in_input & data_b_in_enable_i & ~b_held_q;
    a_val    = a_held_q ? a_q : data_a_in_i;
    b_val    = b_held_q ? b_q : data_b_in_i;
    pair     = in_input & (a_held_q | data_a_in_enable_i) & (b_held_q | data_b_in_enable_i);
    diff     = {1'b0, a_val} - {1'b0, b_val};
    last     = idx_q == IW'(SIZE_IN - 1);
  end
`ifdef NTM_VECTOR_SUBTRACTOR_SATURATE_EN
  assign res = diff[DATA_SIZE] ? '0 : diff;
`else
  assign res = diff;
`endif
  always_comb begin
    state_d  = state_q == IDLE ? (start_i ? INPUT : IDLE)
             : in_input ? ((pair && last) ? ENDER : INPUT) : IDLE;
    idx_d    = state_q == IDLE ? '0 : (pair && !last) ? idx_q + 1'b1 : idx_q;
    a_held_d = pair ? 1'b0 : a_held_q | a_take;
    b_held_d = pair ? 1'b0 : b_held_q | b_take;
    a_d      = a_take ? data_a_in_i : a_q;
    b_d      = b_take ? data_b_in_i : b_q;
    out_d    = pair ? res : out_q;
    oe_d     = pair;
    ready_d  = pair & last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      oe_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_held_q <= a_held_d;
      b_held_q <= b_held_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      ready_q  <= ready_d;
    end
  end
  assign data_enable_o     = state_q == INPUT;
  assign data_out_o        = out_q;
  assign data_out_enable_o = oe_q;
  assign ready_o           = ready_q;
endmodule

// File: tb/tb_ntm_vector_subtractor.sv
// tb_ntm_vector_subtractor: table vectors, corner sequences and randomized streams against a queue-based model.
// Expectations follow NTM_VECTOR_SUBTRACTOR_SATURATE_EN when defined.
module tb_ntm_vector_subtractor;
  logic clk = 0, rst_n = 0, start = 0, s1 = 0, ae = 0, be = 0;
  logic [7:0] a = 0, b = 0;
  logic de, oe, rdy, de1, oe1, rdy1;
  logic [8:0] dout, dout1;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [8:0] e; } elem_t;
  elem_t tbl[12];
  always #5 clk = ~clk;
  ntm_vector_subtractor #(.DATA_SIZE(8), .SIZE_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .data_a_in_enable_i(ae), .data_a_in_i(a), .data_b_in_enable_i(be), .data_b_in_i(b),
    .data_enable_o(de), .data_out_o(dout), .data_out_enable_o(oe), .ready_o(rdy));
  ntm_vector_subtractor #(.DATA_SIZE(8), .SIZE_IN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(s1),
    .data_a_in_enable_i(ae), .data_a_in_i(a), .data_b_in_enable_i(be), .data_b_in_i(b),
    .data_enable_o(de1), .data_out_o(dout1), .data_out_enable_o(oe1), .ready_o(rdy1));
  function automatic logic [8:0] fix(input logic [8:0] e);
`ifdef NTM_VECTOR_SUBTRACTOR_SATURATE_EN
    return e[8] ? 9'd0 : e;
`else
    return e;
`endif
  endfunction
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
    int d = int'(x) - int'(y);
`ifdef NTM_VECTOR_SUBTRACTOR_SATURATE_EN
    if (d < 0) d = 0;
`endif
    return 9'(d);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic ea, input logic [7:0] va, input logic eb, input logic [7:0] vb);
    start = s; ae = ea; a = va; be = eb; b = vb;
    @(posedge clk);
    #1;
  endtask
  task automatic do_pair(input logic [7:0] va, input logic [7:0] vb, input logic lst, input string nm);
    cyc(0, 1, va, 1, vb);
    chk({nm, "_out"}, dout, ref_sub(va, vb));
    chk({nm, "_oe"}, oe, 1);
    chk({nm, "_rdy"}, rdy, lst);
  endtask
  task automatic run_vec(input int base, input string nm);
    cyc(1, 0, 0, 0, 0);
    chk({nm, "_de_start"}, de, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, tbl[base+k].a, 1, tbl[base+k].b);
      chk($sformatf("%s_out%0d", nm, k), dout, fix(tbl[base+k].e));
      chk($sformatf("%s_oe%0d", nm, k), oe, 1);
      chk($sformatf("%s_rdy%0d", nm, k), rdy, k == 3);
    end
    chk({nm, "_de_ender"}, de, 0);
    cyc(0, 0, 0, 0, 0);
    chk({nm, "_oe_after"}, oe, 0);
    chk({nm, "_rdy_after"}, rdy, 0);
    chk({nm, "_hold"}, dout, fix(tbl[base+3].e));
    chk({nm, "_de_idle"}, de, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] qa[$], qb[$];
    logic [7:0] va, vb;
    logic ea, eb, s, exp_oe;
    logic [8:0] exp_out;
    int got, budget;
    tbl = '{'{10, 3, 9'h007}, '{200, 100, 9'h064}, '{0, 0, 9'h000}, '{255, 0, 9'h0FF},
            '{5, 9, 9'h1FC},  '{0, 255, 9'h101},   '{255, 0, 9'h0FF}, '{128, 128, 9'h000},
            '{1, 4, 9'h1FD},  '{2, 3, 9'h1FF},     '{3, 2, 9'h001},   '{4, 1, 9'h003}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_de", de, 0);
    chk("rst_oe", oe, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_out", dout, 0);
    chk("rst_rdy1", rdy1, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    for (int v = 0; v < 3; v++) run_vec(4 * v, $sformatf("tbl%0d", v));
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 77, 1, 11);
      chk("idle_en_oe", oe, 0);
      chk("idle_en_de", de, 0);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 50, 0, 0);
    chk("skew_a_oe", oe, 0);
    cyc(0, 1, 99, 0, 0);
    chk("skew_a2_oe", oe, 0);
    cyc(0, 0, 0, 0, 0);
    chk("skew_gap_oe", oe, 0);
    cyc(0, 0, 0, 1, 20);
    chk("skew_out", dout, ref_sub(50, 20));
    chk("skew_oe", oe, 1);
    cyc(1, 0, 0, 0, 0);
    chk("midstart_oe", oe, 0);
    chk("midstart_de", de, 1);
    do_pair(1, 1, 0, "mid1");
    do_pair(200, 1, 0, "mid2");
    do_pair(9, 5, 1, "mid3");
    cyc(0, 0, 0, 0, 0);
    chk("mid_idle_de", de, 0);
    cyc(1, 0, 0, 0, 0);
    do_pair(30, 10, 0, "pre_rst1");
    do_pair(5, 9, 0, "pre_rst2");
    #2 rst_n = 0;
    #1;
    chk("arst_out", dout, 0);
    chk("arst_oe", oe, 0);
    chk("arst_rdy", rdy, 0);
    chk("arst_de", de, 0);
    @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_de", de, 0);
    run_vec(0, "post_rst");
    s1 = 1;
    @(posedge clk);
    #1 s1 = 0;
    chk("one_de", de1, 1);
    cyc(0, 1, 5, 1, 9);
    chk("one_out", dout1, ref_sub(5, 9));
    chk("one_oe", oe1, 1);
    chk("one_rdy", rdy1, 1);
    chk("one_de_ender", de1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("one_rdy_after", rdy1, 0);
    chk("one_oe_after", oe1, 0);
    chk("one_de_idle", de1, 0);
    for (int v = 0; v < 20; v++) begin
      qa.delete();
      qb.delete();
      got = 0;
      budget = 200;
      cyc(1, 0, 0, 0, 0);
      while (got < 4 && budget > 0) begin
        budget--;
        ea = 1'($urandom_range(0, 1));
        eb = 1'($urandom_range(0, 1));
        va = 8'($urandom);
        vb = 8'($urandom);
        s = $urandom_range(0, 7) == 0;
        if (ea && qa.size() == 0) qa.push_back(va);
        if (eb && qb.size() == 0) qb.push_back(vb);
        exp_oe = qa.size() == 1 && qb.size() == 1;
        exp_out = 0;
        if (exp_oe) begin
          exp_out = ref_sub(qa.pop_front(), qb.pop_front());
          got++;
        end
        cyc(s, ea, va, eb, vb);
        chk("rnd_oe", oe, exp_oe);
        if (exp_oe) chk("rnd_out", dout, exp_out);
        chk("rnd_rdy", rdy, exp_oe && got == 4);
        chk("rnd_de", de, got < 4);
      end
      if (got < 4) begin
        n_chk++;
        n_fail++;
        $display("FAIL rnd_budget: got %0d elements expected 4", got);
      end
      cyc(0, 0, 0, 0, 0);
      chk("rnd_end_rdy", rdy, 0);
      chk("rnd_end_de", de, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
